// File: rtl/alu_sequencer.sv
// Fetch/decode/execute/writeback sequencer for the 8-bit ALU: owns the PC,
// the instruction register and the sticky condition flag.
module alu_sequencer #(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 9
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [5:0]         alu_opcode,
  input  logic [7:0]         alu_result,
  input  logic               alu_overflow,
  output logic [2:0]         rf_raddr1,
  output logic [2:0]         rf_raddr2,
  output logic               rf_we,
  output logic [2:0]         rf_waddr,
  output logic [7:0]         rf_wdata,
  output logic               flag,
  output logic               halted,
  output logic               busy
);

  // IDLE wait start | FETCH rom handshake | DECODE resolve branch/halt | EXEC ALU samples | WB write back | HALTED terminal
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALTED
  } state_t;

  state_t             state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic               flag_q, flag_d;

  logic [2:0]      op, fn, rr;
  logic            is_rtype, is_atype, is_btype;
  logic            a_alu, a_halt, br_taken, wr_result, wr_flag;
  logic [PC_W-1:0] pc_inc, br_target;

  assign op = ir_q[8:6];
  assign fn = ir_q[5:3];
  assign rr = ir_q[2:0];

  assign is_rtype = (op >= 3'b010) && (op <= 3'b101);
  assign is_atype = (op == 3'b110);
  assign is_btype = (op == 3'b111);
  assign a_alu    = is_atype && (fn != 3'b110) && (fn != 3'b111);
  assign a_halt   = is_atype && (fn == 3'b111);
  assign br_taken = is_btype && (((fn == 3'b000) && !flag_q) ||
                                 ((fn == 3'b001) &&  flag_q));

  // ADD and DIST among R-types; LSL/LSR/INCR/ZERO among A-types
  assign wr_result = (is_rtype && ((op == 3'b010) || (op == 3'b101))) ||
                     (is_atype && ((fn == 3'b000) || (fn == 3'b001) ||
                                   (fn == 3'b010) || (fn == 3'b101)));
  assign wr_flag   = (is_rtype && (op != 3'b101)) ||
                     (is_atype && ((fn == 3'b011) || (fn == 3'b100)));

  assign pc_inc    = pc_q + PC_W'(1);
  assign br_target = pc_inc + {{(PC_W-3){rr[2]}}, rr};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
      flag_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      flag_q  <= flag_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    flag_d   = flag_q;
    imem_req = 1'b0;
    rf_we    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          pc_d    = '0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_d    = imem_data;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (a_halt) begin
          state_d = S_HALTED;
        end else if (is_rtype || a_alu) begin
          state_d = S_EXEC;
        end else begin
          pc_d    = br_taken ? br_target : pc_inc;
          state_d = S_FETCH;
        end
      end
      S_EXEC: state_d = S_WB;
      S_WB: begin
        rf_we = wr_result;
        if (wr_flag) flag_d = alu_overflow;
        pc_d    = pc_inc;
        state_d = S_FETCH;
      end
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_IDLE;
    endcase
  end

  assign imem_addr  = pc_q;
  assign alu_opcode = {op, fn};
  assign rf_raddr1  = fn;
  assign rf_raddr2  = rr;
  assign rf_waddr   = is_atype ? rr : fn;
  assign rf_wdata   = alu_result;
  assign flag       = flag_q;
  assign halted     = (state_q == S_HALTED);
  assign busy       = (state_q != S_IDLE) && (state_q != S_HALTED);

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: ROM, register file and registered ALU models around
// the DUT, with an instruction-level interpreter predicting fetches, writes and cycles.
module tb_alu_sequencer;

  logic       clk, rst_n, start;
  logic       imem_req, imem_ack;
  logic [7:0] imem_addr;
  logic [8:0] imem_data;
  logic [5:0] alu_opcode;
  logic [7:0] alu_result;
  logic       alu_overflow;
  logic [2:0] rf_raddr1, rf_raddr2, rf_waddr;
  logic       rf_we;
  logic [7:0] rf_wdata;
  logic       flag, halted, busy;

  alu_sequencer #(.PC_W(8), .INSTR_W(9)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
    .alu_opcode(alu_opcode), .alu_result(alu_result), .alu_overflow(alu_overflow),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_we(rf_we), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .flag(flag), .halted(halted), .busy(busy)
  );

  localparam logic [8:0] HALT = 9'b110_111_000;
  localparam logic [8:0] NOP  = 9'b000_000_000;

  int checks = 0;
  int errors = 0;

  logic [8:0] rom [256];
  logic [7:0] rf_init [8];
  logic [7:0] rf [8];
  logic       load_req;
  int         wait_cfg;
  bit         spurious;

  logic [7:0]  fetch_q [$];
  logic [10:0] wr_q [$];
  int          busy_cnt;

  logic [7:0]  exp_fetch [$];
  logic [10:0] exp_wr [$];
  logic [7:0]  exp_rf [8];
  logic        exp_flag, exp_halted;
  int          exp_cycles;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU semantics, used both by the registered ALU stand-in and the interpreter.
  function automatic logic [8:0] alu_fn(input logic [5:0] opc, input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = '0;
    case (opc[5:3])
      3'b010: s = {1'b0, a} + {1'b0, b};
      3'b011: s = {(a == b), 8'h00};
      3'b100: s = {($signed(a) < $signed(b)), 8'h00};
      3'b101: s = {1'b0, (a > b) ? (a - b) : (b - a)};
      3'b110: begin
        case (opc[2:0])
          3'd0: s = {1'b0, b << 1};
          3'd1: s = {1'b0, b >> 1};
          3'd2: s = {1'b0, b + 8'd1};
          3'd3: s = {b[0], 8'h00};
          3'd4: s = {(b == 8'h00), 8'h00};
          default: s = '0;
        endcase
      end
      default: s = '0;
    endcase
    return s;
  endfunction

  always @(posedge clk)
    {alu_overflow, alu_result} <= alu_fn(alu_opcode, rf[rf_raddr1], rf[rf_raddr2]);

  always @(posedge clk) begin
    if (load_req) begin
      for (int i = 0; i < 8; i++) rf[i] <= rf_init[i];
    end else if (rf_we) begin
      rf[rf_waddr] <= rf_wdata;
    end
  end

  // ROM with programmable wait states; optionally acks while no request is pending.
  initial begin
    int wcnt;
    wcnt = 0;
    imem_ack = 1'b0;
    imem_data = '0;
    forever begin
      @(negedge clk);
      if (imem_req === 1'b1) begin
        if (wcnt >= wait_cfg) begin
          imem_ack = 1'b1; imem_data = rom[imem_addr]; wcnt = 0;
        end else begin
          imem_ack = 1'b0; imem_data = 9'($urandom); wcnt++;
        end
      end else begin
        wcnt = 0;
        imem_ack = spurious;
        imem_data = 9'($urandom);
      end
    end
  end

  always begin
    @(negedge clk);
    #2;
    if (busy === 1'b1) busy_cnt++;
    if (imem_req === 1'b1 && imem_ack === 1'b1) fetch_q.push_back(imem_addr);
    if (rf_we === 1'b1) wr_q.push_back({rf_waddr, rf_wdata});
  end

  task automatic sample();
    @(negedge clk);
    #2;
  endtask

  task automatic fill_rom(input logic [8:0] w);
    for (int i = 0; i < 256; i++) rom[i] = w;
  endtask

  task automatic set_rf_zero();
    for (int i = 0; i < 8; i++) rf_init[i] = 8'h00;
  endtask

  task automatic start_prog();
    rst_n = 1'b0; load_req = 1'b1; start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1; load_req = 1'b0;
    fetch_q.delete(); wr_q.delete(); busy_cnt = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  // Instruction-level interpreter: runs the ROM from PC 0 until HALT or the instruction limit.
  task automatic model_run(input int max_instr);
    logic [7:0] pc, a, b;
    logic [7:0] regs [8];
    logic [8:0] ins, r9;
    logic [2:0] op, fn, r, dest;
    logic       f;
    exp_fetch.delete(); exp_wr.delete();
    for (int i = 0; i < 8; i++) regs[i] = rf_init[i];
    pc = 8'd0; f = 1'b0; exp_halted = 1'b0; exp_cycles = 0;
    for (int n = 0; n < max_instr && !exp_halted; n++) begin
      ins = rom[pc]; op = ins[8:6]; fn = ins[5:3]; r = ins[2:0];
      exp_fetch.push_back(pc);
      exp_cycles += 2 + wait_cfg;
      if ((op >= 3'd2 && op <= 3'd5) || (op == 3'd6 && fn <= 3'd5)) begin
        exp_cycles += 2;
        a = regs[fn]; b = regs[r];
        r9 = alu_fn({op, fn}, a, b);
        dest = (op == 3'd6) ? r : fn;
        if (op == 3'd2 || op == 3'd5 || (op == 3'd6 && (fn == 3'd0 || fn == 3'd1 || fn == 3'd2 || fn == 3'd5))) begin
          regs[dest] = r9[7:0];
          exp_wr.push_back({dest, r9[7:0]});
        end
        if (op == 3'd2 || op == 3'd3 || op == 3'd4 || (op == 3'd6 && (fn == 3'd3 || fn == 3'd4)))
          f = r9[8];
        pc = pc + 8'd1;
      end else if (op == 3'd6 && fn == 3'd7) begin
        exp_halted = 1'b1;
      end else if (op == 3'd7 && ((fn == 3'd0 && !f) || (fn == 3'd1 && f))) begin
        pc = pc + 8'd1 + {{5{r[2]}}, r};
      end else begin
        pc = pc + 8'd1;
      end
    end
    exp_flag = f;
    for (int i = 0; i < 8; i++) exp_rf[i] = regs[i];
  endtask

  task automatic wait_halt(input string name, input int budget);
    int i;
    i = 0;
    while (halted !== 1'b1 && i < budget) begin
      sample();
      i++;
    end
    checks++;
    if (halted !== 1'b1) begin
      errors++;
      $display("FAIL %s halt timeout: halted=%b after %0d cycles, expected 1", name, halted, i);
    end
  endtask

  task automatic check_run(input string name);
    checks++;
    if (fetch_q.size() != exp_fetch.size()) begin
      errors++;
      $display("FAIL %s fetch count: got %0d expected %0d", name, fetch_q.size(), exp_fetch.size());
    end else begin
      for (int i = 0; i < fetch_q.size(); i++) begin
        checks++;
        if (fetch_q[i] !== exp_fetch[i]) begin
          errors++;
          $display("FAIL %s fetch[%0d] addr: got %0d expected %0d", name, i, fetch_q[i], exp_fetch[i]);
        end
      end
    end
    checks++;
    if (wr_q.size() != exp_wr.size()) begin
      errors++;
      $display("FAIL %s write count: got %0d expected %0d", name, wr_q.size(), exp_wr.size());
    end else begin
      for (int i = 0; i < wr_q.size(); i++) begin
        checks++;
        if (wr_q[i] !== exp_wr[i]) begin
          errors++;
          $display("FAIL %s write[%0d] {addr,data}: got %h expected %h", name, i, wr_q[i], exp_wr[i]);
        end
      end
    end
    checks++;
    if (flag !== exp_flag) begin
      errors++;
      $display("FAIL %s flag: got %b expected %b", name, flag, exp_flag);
    end
    checks++;
    if (busy_cnt != exp_cycles) begin
      errors++;
      $display("FAIL %s busy cycles: got %0d expected %0d", name, busy_cnt, exp_cycles);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (rf[i] !== exp_rf[i]) begin
        errors++;
        $display("FAIL %s reg r%0d: got %h expected %h", name, i, rf[i], exp_rf[i]);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; load_req = 1'b1;
    sample(); sample();
    checks++;
    if ({imem_req, rf_we, halted, busy} !== 4'b0000) begin
      errors++;
      $display("FAIL reset strobes {req,we,halted,busy}: got %b expected 0000", {imem_req, rf_we, halted, busy});
    end
    checks++;
    if (alu_opcode !== 6'd0 || imem_addr !== 8'd0) begin
      errors++;
      $display("FAIL reset opcode/addr: got %h/%h expected 00/00", alu_opcode, imem_addr);
    end
    checks++;
    if ({rf_raddr1, rf_raddr2, rf_waddr} !== 9'd0 || flag !== 1'b0) begin
      errors++;
      $display("FAIL reset rf addrs/flag: got %h/%b expected 000/0", {rf_raddr1, rf_raddr2, rf_waddr}, flag);
    end
    rst_n = 1'b1; load_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sample();
      checks++;
      if (busy !== 1'b0 || imem_req !== 1'b0) begin
        errors++;
        $display("FAIL idle without start: busy=%b req=%b expected 0/0", busy, imem_req);
      end
    end
  endtask

  task automatic test_add();
    fill_rom(HALT); set_rf_zero();
    rom[0] = 9'b010_001_010;
    rf_init[1] = 8'd200; rf_init[2] = 8'd100;
    wait_cfg = 0; spurious = 1'b0;
    model_run(16);
    start_prog();
    wait_halt("add", 50);
    check_run("add");
    checks++;
    if (wr_q.size() != 1 || wr_q[0] !== {3'd1, 8'd44}) begin
      errors++;
      $display("FAIL add writeback: got %0d writes, first %h expected 1 write of %h", wr_q.size(), wr_q[0], {3'd1, 8'd44});
    end
    checks++;
    if (busy_cnt != 6 || flag !== 1'b1) begin
      errors++;
      $display("FAIL add cycles/flag: got %0d/%b expected 6/1", busy_cnt, flag);
    end
  endtask

  task automatic test_halt();
    int reqs;
    reqs = 0;
    sample();
    checks++;
    if (halted !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL halt state: halted=%b busy=%b expected 1/0", halted, busy);
    end
    for (int i = 0; i < 4; i++) begin sample(); if (imem_req === 1'b1) reqs++; end
    start = 1'b1; sample(); start = 1'b0;
    for (int i = 0; i < 4; i++) begin sample(); if (imem_req === 1'b1) reqs++; end
    checks++;
    if (reqs != 0 || halted !== 1'b1) begin
      errors++;
      $display("FAIL halt sticky: req cycles=%0d halted=%b expected 0/1", reqs, halted);
    end
    @(negedge clk); #3 rst_n = 1'b0; #1;
    checks++;
    if ({halted, busy, imem_req, rf_we, flag} !== 5'b00000) begin
      errors++;
      $display("FAIL halt reset {halted,busy,req,we,flag}: got %b expected 00000", {halted, busy, imem_req, rf_we, flag});
    end
    checks++;
    if (alu_opcode !== 6'd0 || imem_addr !== 8'd0 || {rf_raddr1, rf_raddr2, rf_waddr} !== 9'd0) begin
      errors++;
      $display("FAIL halt reset opcode/addr: got %h/%h/%h expected 0/0/0", alu_opcode, imem_addr, {rf_raddr1, rf_raddr2, rf_waddr});
    end
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_fetch_wait();
    fill_rom(HALT); set_rf_zero();
    rom[0] = 9'b010_001_010;
    rf_init[1] = 8'd200; rf_init[2] = 8'd100;
    wait_cfg = 3; spurious = 1'b1;
    model_run(16);
    start_prog();
    for (int i = 0; i < 4; i++) begin
      #2;
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 8'd0 || imem_ack !== (i == 3)) begin
        errors++;
        $display("FAIL wait cycle %0d req/addr/ack: got %b/%0d/%b expected 1/0/%b", i, imem_req, imem_addr, imem_ack, (i == 3));
      end
      @(negedge clk);
    end
    wait_halt("fetch_wait", 60);
    check_run("fetch_wait");
    spurious = 1'b0; wait_cfg = 0;
  endtask

  task automatic test_branch();
    int bad;
    fill_rom(HALT); set_rf_zero();
    rom[0] = 9'b100_011_100;
    rom[1] = 9'b111_001_111;
    rf_init[3] = 8'hF0; rf_init[4] = 8'd5;
    wait_cfg = 0; spurious = 1'b0;
    start_prog();
    for (int i = 0; i < 20; i++) sample();
    bad = 0;
    for (int i = 1; i < fetch_q.size(); i++) if (fetch_q[i] !== 8'd1) bad++;
    checks++;
    if (fetch_q.size() < 6 || fetch_q[0] !== 8'd0 || bad != 0) begin
      errors++;
      $display("FAIL bof self-loop: fetches=%0d first=%0d off-target=%0d expected >=6/0/0", fetch_q.size(), fetch_q[0], bad);
    end
    checks++;
    if (flag !== 1'b1 || wr_q.size() != 0 || halted !== 1'b0) begin
      errors++;
      $display("FAIL lt flag-only: flag=%b writes=%0d halted=%b expected 1/0/0", flag, wr_q.size(), halted);
    end
    rom[1] = 9'b111_000_111;
    model_run(16);
    start_prog();
    wait_halt("bno", 40);
    check_run("bno");
    checks++;
    if (fetch_q.size() != 3 || fetch_q[2] !== 8'd2) begin
      errors++;
      $display("FAIL bno fallthrough: fetches=%0d third=%0d expected 3/2", fetch_q.size(), fetch_q[2]);
    end
  endtask

  task automatic test_pc_wrap();
    int n;
    fill_rom(HALT); set_rf_zero();
    wait_cfg = 0; spurious = 1'b0;
    rom[0] = 9'b011_000_000;
    rom[1] = 9'b111_001_001;
    for (int i = 3; i < 254; i++) rom[i] = NOP;
    rom[254] = 9'b111_001_011;
    model_run(1000);
    start_prog();
    wait_halt("bof_wrap", 1000);
    check_run("bof_wrap");
    n = fetch_q.size();
    checks++;
    if (n < 2 || fetch_q[n-2] !== 8'd254 || fetch_q[n-1] !== 8'd2) begin
      errors++;
      $display("FAIL bof wrap target: tail %0d,%0d expected 254,2", fetch_q[n-2], fetch_q[n-1]);
    end
    fill_rom(HALT);
    rom[0] = 9'b111_000_001;
    rom[2] = 9'b011_000_000;
    for (int i = 3; i < 256; i++) rom[i] = NOP;
    model_run(1000);
    start_prog();
    wait_halt("pc_wrap", 1000);
    check_run("pc_wrap");
    n = fetch_q.size();
    checks++;
    if (n < 3 || fetch_q[n-3] !== 8'd255 || fetch_q[n-2] !== 8'd0 || fetch_q[n-1] !== 8'd1) begin
      errors++;
      $display("FAIL pc 255+1 wrap: tail %0d,%0d,%0d expected 255,0,1", fetch_q[n-3], fetch_q[n-2], fetch_q[n-1]);
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    fill_rom(HALT); set_rf_zero();
    rom[0] = 9'b101_001_010;
    rf_init[1] = 8'd10; rf_init[2] = 8'd3;
    wait_cfg = 0; spurious = 1'b0;
    start_prog();
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      sample();
      if (rf_we === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL dist wb: rf_we=%b never seen, expected 1", rf_we);
    end
    #1 rst_n = 1'b0; #1;
    checks++;
    if (rf_we !== 1'b0 || busy !== 1'b0 || imem_addr !== 8'd0 || flag !== 1'b0) begin
      errors++;
      $display("FAIL reset in wb we/busy/pc/flag: got %b/%b/%0d/%b expected 0/0/0/0", rf_we, busy, imem_addr, flag);
    end
    @(posedge clk); #1;
    checks++;
    if (rf[1] !== 8'd10) begin
      errors++;
      $display("FAIL reset in wb no write: r1=%0d expected 10", rf[1]);
    end
    wait_cfg = 3;
    start_prog();
    sample();
    checks++;
    if (imem_req !== 1'b1) begin
      errors++;
      $display("FAIL mid-fetch pre-reset req: got %b expected 1", imem_req);
    end
    #1 rst_n = 1'b0; #1;
    checks++;
    if (imem_req !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset in fetch req/busy: got %b/%b expected 0/0", imem_req, busy);
    end
    @(negedge clk) rst_n = 1'b1;
    wait_cfg = 0;
  endtask

  task automatic test_random();
    logic [2:0] op, fn, r;
    for (int k = 0; k < 8; k++) begin
      fill_rom(HALT);
      for (int i = 0; i < 8; i++) rf_init[i] = 8'($urandom);
      wait_cfg = $urandom_range(0, 2);
      spurious = 1'($urandom_range(0, 1));
      for (int i = 0; i < 24; i++) begin
        op = 3'($urandom_range(0, 7));
        fn = 3'($urandom_range(0, 7));
        r  = 3'($urandom_range(0, 7));
        if (op == 3'd7) r = 3'($urandom_range(0, 3));
        if (op == 3'd6 && fn == 3'd7) fn = 3'($urandom_range(0, 6));
        rom[i] = {op, fn, r};
      end
      model_run(200);
      start_prog();
      wait_halt("random", 600);
      check_run("random");
    end
    spurious = 1'b0; wait_cfg = 0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; load_req = 1'b0;
    wait_cfg = 0; spurious = 1'b0; busy_cnt = 0;
    fill_rom(HALT); set_rf_zero();
    test_reset();
    test_add();
    test_halt();
    test_fetch_wait();
    test_branch();
    test_pc_wrap();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Multi-cycle control FSM that sequences the 8-bit ALU. It fetches 9-bit instructions from the instruction ROM over a req/ack handshake and decodes them into the ALU's 6-bit OPCODE and register-file read/write controls. It owns the PC and the sticky condition flag fed by the ALU overflow bit. It also resolves BNO/BOF branches and HALT. It sits between the fetch unit/ROM, the register file and the ALU.

## Interface
Parameters:
- PC_W, 8, PC and instruction-address width
- INSTR_W, 9, instruction width (fixed format below; not intended to change)

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  begin execution at PC 0; honoured only in IDLE
- imem_req  out  1  fetch request
- imem_addr  out  PC_W  fetch address (= PC)
- imem_ack  in  1  ROM ack; imem_data is valid in the same cycle
- imem_data  in  INSTR_W  instruction word
- alu_opcode  out  6  to ALU OPCODE, {op, func}
- alu_result  in  8  ALU result, valid one cycle after alu_opcode is presented (ALU is registered)
- alu_overflow  in  1  ALU overflow/condition bit, same timing as alu_result
- rf_raddr1  out  3  register-file read address, drives ALU IN1
- rf_raddr2  out  3  register-file read address, drives ALU IN2
- rf_we  out  1  register write strobe, single-cycle pulse
- rf_waddr  out  3  write address
- rf_wdata  out  8  write data (= alu_result)
- flag  out  1  condition flag
- halted  out  1  high once HALT has executed
- busy  out  1  high in every state except IDLE and HALTED

## Operation
Instruction format: op = instr[8:6], f = instr[5:3], r = instr[2:0]. alu_opcode = {op, f} at all times after decode.

Op classes:
- op 010 ADD, 011 MATCH, 100 LT, 101 DIST (R-type): raddr1 = f, raddr2 = r; destination is f.
- op 110 (A-type): f is the function; raddr2 = r; destination is r.
  - LSL(000), LSR(001), INCR(010), ZERO(101) write the result.
  - AND1(011), EQZ(100) write only the flag.
  - TBD(110) is a NOP.
  - HALT(111) halts.
- op 111 (B-type): f = 000 BNO, branch if flag == 0; f = 001 BOF, branch if flag == 1. Target is PC + 1 + sext(r), where r is signed −4..+3. Other f values are a NOP.
- op 000 and 001 are NOPs.

Writeback effects:
- ADD writes the result and flag = overflow.
- MATCH and LT write only the flag.
- DIST writes only the result.

FSM states:
- IDLE: exits to FETCH on start.
- FETCH: imem_req = 1, imem_addr = PC. On imem_ack, latch IR and go to DECODE.
- DECODE: drive alu_opcode and raddr.
  - Branch taken: PC = target, go to FETCH.
  - Branch not taken or NOP: PC + 1, go to FETCH.
  - HALT: go to HALTED.
  - Otherwise: go to EXEC.
- EXEC: hold alu_opcode and raddr; the ALU samples them at the end of this cycle. Go to WB.
- WB: rf_we pulses if the op writes a result (rf_waddr per class, rf_wdata = alu_result). The flag updates if the op writes the flag. PC + 1, go to FETCH.
- HALTED: terminal. start is ignored; only rst_n exits.

Arithmetic and boundaries:
- PC arithmetic is modulo 2^PC_W. 255 + 1 = 0, and a branch target wraps the same way.
- The flag is sticky: it changes only in WB of flag-writing ops.
- The flag is sampled in DECODE, so a branch immediately after a flag-writing op sees the updated value.

## Timing
- Reset (async, immediate) values:
  - State = IDLE; PC = 0; IR = 0; flag = 0.
  - imem_req = 0, rf_we = 0, halted = 0, busy = 0.
  - alu_opcode = 0, all addresses = 0.
- start is level-sampled in IDLE and ignored in every other state.
- FETCH handshake:
  - imem_req and imem_addr stay stable until imem_ack is sampled high.
  - Zero-wait ack means FETCH lasts 1 cycle; each wait cycle adds 1.
  - imem_ack outside FETCH is ignored.
- Cycles per instruction with zero-wait ROM:
  - ALU ops: 4 (FETCH, DECODE, EXEC, WB).
  - Branch or NOP: 2.
  - HALT: halted rises 2 cycles after FETCH begins.
- rf_we is high for exactly one cycle, in WB only.
- rst_n low mid-fetch or mid-WB: imem_req and rf_we drop in the same cycle. No write completes.

## Test plan
- Reset, then start with ROM [ADD r1,r2] where r1 = 200, r2 = 100 → rf_we pulses once, rf_waddr = 1, rf_wdata = 44, flag = 1, PC = 1, 4 cycles.
- ROM ack delayed 3 cycles → imem_req and imem_addr held constant for 4 cycles, then decode proceeds. Spurious ack in EXEC is ignored.
- LT r3,r4 with r3 = 0xF0 (−16), r4 = 5 → flag = 1, no rf_we. Next BOF r = 111 (−1) → PC loops to itself. The same sequence with BNO → PC + 1.
- PC = 255 executing NOP → next fetch address 0. BOF +3 at PC 254 with flag = 1 → target 2.
- A-type HALT → halted = 1, busy = 0, no further imem_req. start pulse → still halted. rst_n low → all outputs at reset values.
- rst_n asserted in the WB cycle of DIST → rf_we = 0 immediately, PC = 0, flag unchanged from reset (0).
